bcd_scan_display: RTL and testbench

- Downstream consumer of the 4-digit BCD gated-period counter.
- Latches the 16-bit packed BCD count on a load request.
- Time-multiplexes the four digits onto a common-anode 7-segment display, with leading-zero blanking and non-BCD error flagging.
- Runs entirely in the Counter_clk domain.

---
 rtl/bcd_scan_display_if.sv | 22 ++
 rtl/bcd_scan_display.sv | 153 +++++++++++++++
 tb/tb_bcd_scan_display.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_scan_display_if.sv
// Bus between the BCD counter side and the 7-segment scan display.
// The master drives the count and capture controls; the slave (display) returns
// the segment/anode drive and status flags.
interface bcd_scan_display_if;
  logic [15:0] Cnt_in;
  logic        Load;
  logic        Hold;
  logic [6:0]  Seg;
  logic [3:0]  An;
  logic        Valid;
  logic        Err;

  modport master (
    output Cnt_in, Load, Hold,
    input  Seg, An, Valid, Err
  );

  modport slave (
    input  Cnt_in, Load, Hold,
    output Seg, An, Valid, Err
  );
endinterface

// File: rtl/bcd_scan_display.sv
// Latches a packed 4-digit BCD count on a Load rising edge and time-multiplexes
// it onto a common-anode 7-segment display with leading-zero blanking and
// dash display for non-BCD nibbles. Single clock domain (Counter_clk).
module bcd_scan_display #(
  parameter logic [15:0] SCAN_DIV = 16'd5000,
  parameter logic        BLANK_LZ = 1'b1
) (
  input logic Counter_clk,
  input logic clr,
  bcd_scan_display_if.slave bus
);

  typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} digit_t;

  digit_t      state;
  digit_t      next_state;
  logic [15:0] Disp_reg;
  logic [15:0] prescaler;
  logic        Load_d;
  logic        capture;
  logic        scan_tick;
  logic        cnt_has_err;
  logic        valid_q;
  logic        err_q;
  logic [6:0]  seg_q;
  logic [6:0]  seg_next;
  logic [6:0]  seg_dec;
  logic [3:0]  an_q;
  logic [3:0]  an_next;
  logic [3:0]  nibble;
  logic        blank;

  assign capture   = bus.Load & ~Load_d & ~bus.Hold;
  assign scan_tick = (prescaler == SCAN_DIV - 16'd1);

  assign cnt_has_err = (bus.Cnt_in[3:0]   > 4'd9) | (bus.Cnt_in[7:4]   > 4'd9) |
                       (bus.Cnt_in[11:8]  > 4'd9) | (bus.Cnt_in[15:12] > 4'd9);

  assign bus.Seg   = seg_q;
  assign bus.An    = an_q;
  assign bus.Valid = valid_q;
  assign bus.Err   = err_q;

  // Load edge detection and capture of the count, validity and error flag
  always_ff @(posedge Counter_clk or negedge clr) begin
    if (!clr) begin
      Load_d   <= 1'b0;
      Disp_reg <= 16'h0000;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      Load_d <= bus.Load;
      if (capture) begin
        Disp_reg <= bus.Cnt_in;
        valid_q  <= 1'b1;
        err_q    <= cnt_has_err;
      end
    end
  end

  // Scan prescaler: wraps at SCAN_DIV-1, which is also the digit-advance tick
  always_ff @(posedge Counter_clk or negedge clr) begin
    if (!clr) begin
      prescaler <= 16'h0000;
    end else if (scan_tick) begin
      prescaler <= 16'h0000;
    end else begin
      prescaler <= prescaler + 16'd1;
    end
  end

  // Digit FSM state register
  always_ff @(posedge Counter_clk or negedge clr) begin
    if (!clr) begin
      state <= DIG0;
    end else begin
      state <= next_state;
    end
  end

  // Next digit, current nibble selection, blanking and anode pattern
  always_comb begin
    next_state = state;
    nibble     = Disp_reg[3:0];
    blank      = 1'b0;
    an_next    = 4'hE;
    unique case (state)
      DIG0: begin
        if (scan_tick) next_state = DIG1;
        nibble  = Disp_reg[3:0];
        an_next = 4'hE;
      end
      DIG1: begin
        if (scan_tick) next_state = DIG2;
        nibble  = Disp_reg[7:4];
        blank   = BLANK_LZ && (Disp_reg[15:4] == 12'h000);
        an_next = 4'hD;
      end
      DIG2: begin
        if (scan_tick) next_state = DIG3;
        nibble  = Disp_reg[11:8];
        blank   = BLANK_LZ && (Disp_reg[15:8] == 8'h00);
        an_next = 4'hB;
      end
      DIG3: begin
        if (scan_tick) next_state = DIG0;
        nibble  = Disp_reg[15:12];
        blank   = BLANK_LZ && (Disp_reg[15:12] == 4'h0);
        an_next = 4'h7;
      end
      default: begin
        next_state = DIG0;
      end
    endcase
    if (!valid_q) begin
      an_next = 4'hF;
    end
  end

  // Active-low BCD to 7-segment decode; non-BCD nibbles show a dash
  always_comb begin
    seg_dec = 7'h3F;
    case (nibble)
      4'd0:    seg_dec = 7'h40;
      4'd1:    seg_dec = 7'h79;
      4'd2:    seg_dec = 7'h24;
      4'd3:    seg_dec = 7'h30;
      4'd4:    seg_dec = 7'h19;
      4'd5:    seg_dec = 7'h12;
      4'd6:    seg_dec = 7'h02;
      4'd7:    seg_dec = 7'h78;
      4'd8:    seg_dec = 7'h00;
      4'd9:    seg_dec = 7'h10;
      default: seg_dec = 7'h3F;
    endcase
    seg_next = seg_dec;
    if (blank || !valid_q) begin
      seg_next = 7'h7F;
    end
  end

  // Registered segment and anode drive
  always_ff @(posedge Counter_clk or negedge clr) begin
    if (!clr) begin
      seg_q <= 7'h7F;
      an_q  <= 4'hF;
    end else begin
      seg_q <= seg_next;
      an_q  <= an_next;
    end
  end

endmodule

// File: tb/tb_bcd_scan_display.sv
// Scoreboard bench for bcd_scan_display. Three instances share the same inputs:
// u_a (SCAN_DIV=4, blanking), u_b (SCAN_DIV=2, blanking), u_c (SCAN_DIV=2, no blanking).
// Stimulus pushes hand-computed expectations; a monitor pops and compares them.
module tb_bcd_scan_display;

  typedef struct {
    int         dut;
    string      name;
    logic [3:0] an;
    logic [6:0] seg;
    logic       valid;
    logic       err;
  } exp_t;

  logic        Counter_clk;
  logic        clr;
  logic [15:0] cnt_in;
  logic        load;
  logic        hold;

  exp_t exp_q[$];
  event chk_ev;
  int   pass_cnt;
  int   total_cnt;

  logic [3:0] an_tab   [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
  logic [6:0] seg_1234 [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
  logic [6:0] seg_0a05 [4] = '{7'h12, 7'h40, 7'h3F, 7'h7F};

  bcd_scan_display_if bus_a ();
  bcd_scan_display_if bus_b ();
  bcd_scan_display_if bus_c ();

  assign bus_a.Cnt_in = cnt_in;
  assign bus_a.Load   = load;
  assign bus_a.Hold   = hold;
  assign bus_b.Cnt_in = cnt_in;
  assign bus_b.Load   = load;
  assign bus_b.Hold   = hold;
  assign bus_c.Cnt_in = cnt_in;
  assign bus_c.Load   = load;
  assign bus_c.Hold   = hold;

  bcd_scan_display #(.SCAN_DIV(16'd4), .BLANK_LZ(1'b1)) u_a (
    .Counter_clk (Counter_clk),
    .clr         (clr),
    .bus         (bus_a)
  );

  bcd_scan_display #(.SCAN_DIV(16'd2), .BLANK_LZ(1'b1)) u_b (
    .Counter_clk (Counter_clk),
    .clr         (clr),
    .bus         (bus_b)
  );

  bcd_scan_display #(.SCAN_DIV(16'd2), .BLANK_LZ(1'b0)) u_c (
    .Counter_clk (Counter_clk),
    .clr         (clr),
    .bus         (bus_c)
  );

  // Free-running clock, 10 time units per period
  initial begin
    Counter_clk = 1'b0;
    forever #5 Counter_clk = ~Counter_clk;
  end

  task applyStimulus(input logic [15:0] c, input logic l, input logic h);
    cnt_in = c;
    load   = l;
    hold   = h;
  endtask

  task checkOutput(input int dut, input string name, input logic [3:0] an,
                   input logic [6:0] seg, input logic v, input logic e);
    exp_t x;
    x.dut   = dut;
    x.name  = name;
    x.an    = an;
    x.seg   = seg;
    x.valid = v;
    x.err   = e;
    exp_q.push_back(x);
    -> chk_ev;
  endtask

  // Reset all instances, preset the inputs, then release clr on a falling edge
  task startScan(input logic [15:0] c, input logic l);
    @(negedge Counter_clk);
    clr = 1'b0;
    applyStimulus(c, l, 1'b0);
    @(negedge Counter_clk);
    clr = 1'b1;
  endtask

  // Monitor: drain the scoreboard and compare against the addressed instance
  always begin
    exp_t       e;
    logic [3:0] a_an;
    logic [6:0] a_seg;
    logic       a_v;
    logic       a_e;
    @(chk_ev);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e.dut)
        0:       begin a_an = bus_a.An; a_seg = bus_a.Seg; a_v = bus_a.Valid; a_e = bus_a.Err; end
        1:       begin a_an = bus_b.An; a_seg = bus_b.Seg; a_v = bus_b.Valid; a_e = bus_b.Err; end
        default: begin a_an = bus_c.An; a_seg = bus_c.Seg; a_v = bus_c.Valid; a_e = bus_c.Err; end
      endcase
      total_cnt++;
      if ({a_an, a_seg, a_v, a_e} === {e.an, e.seg, e.valid, e.err}) begin
        pass_cnt++;
      end else begin
        $display("[TB] FAIL %s (dut %0d) t=%0t: got An=%h Seg=%h Valid=%b Err=%b, expected An=%h Seg=%h Valid=%b Err=%b",
                 e.name, e.dut, $time, a_an, a_seg, a_v, a_e, e.an, e.seg, e.valid, e.err);
      end
    end
  end

  // Directed scenarios
  initial begin
    int d;
    pass_cnt  = 0;
    total_cnt = 0;
    clr = 1'b0;
    applyStimulus(16'h0000, 1'b0, 1'b0);

    $display("[TB] idle after reset");
    startScan(16'h1234, 1'b0);
    for (int n = 1; n <= 20; n++) begin
      @(negedge Counter_clk);
      checkOutput(0, "idle", 4'hF, 7'h7F, 1'b0, 1'b0);
    end

    $display("[TB] capture 1234, SCAN_DIV=4");
    startScan(16'h1234, 1'b1);
    @(negedge Counter_clk);
    checkOutput(0, "cap_valid", 4'hF, 7'h7F, 1'b1, 1'b0);
    applyStimulus(16'h1234, 1'b0, 1'b0);
    for (int n = 2; n <= 17; n++) begin
      @(negedge Counter_clk);
      d = ((n - 1) / 4) % 4;
      checkOutput(0, "scan1234", an_tab[d], seg_1234[d], 1'b1, 1'b0);
    end

    $display("[TB] capture 0007, blanking on/off");
    startScan(16'h0007, 1'b1);
    @(negedge Counter_clk);
    applyStimulus(16'h0007, 1'b0, 1'b0);
    for (int n = 2; n <= 9; n++) begin
      @(negedge Counter_clk);
      d = ((n - 1) / 2) % 4;
      checkOutput(1, "blank0007", an_tab[d], (d == 0) ? 7'h78 : 7'h7F, 1'b1, 1'b0);
      checkOutput(2, "noblank0007", an_tab[d], (d == 0) ? 7'h78 : 7'h40, 1'b1, 1'b0);
    end

    $display("[TB] capture 0A05 then 0005");
    startScan(16'h0A05, 1'b1);
    @(negedge Counter_clk);
    checkOutput(1, "err_set", 4'hF, 7'h7F, 1'b1, 1'b1);
    applyStimulus(16'h0A05, 1'b0, 1'b0);
    for (int n = 2; n <= 9; n++) begin
      @(negedge Counter_clk);
      d = ((n - 1) / 2) % 4;
      checkOutput(1, "dash0a05", an_tab[d], seg_0a05[d], 1'b1, 1'b1);
    end
    applyStimulus(16'h0005, 1'b1, 1'b0);
    for (int n = 10; n <= 17; n++) begin
      @(negedge Counter_clk);
      if (n == 10) applyStimulus(16'h0005, 1'b0, 1'b0);
      d = ((n - 1) / 2) % 4;
      checkOutput(1, "err_clear", an_tab[d], (d == 0) ? 7'h12 : 7'h7F, 1'b1, 1'b0);
    end

    $display("[TB] Hold blocks Load edges");
    startScan(16'h1234, 1'b1);
    @(negedge Counter_clk);
    applyStimulus(16'h1234, 1'b0, 1'b0);
    for (int n = 2; n <= 13; n++) begin
      @(negedge Counter_clk);
      d = ((n - 1) / 4) % 4;
      if (n <= 8) checkOutput(0, "hold_keep", an_tab[d], seg_1234[d], 1'b1, 1'b0);
      else        checkOutput(0, "hold_recap", an_tab[d], 7'h10, 1'b1, 1'b0);
      case (n)
        2: applyStimulus(16'h9999, 1'b1, 1'b1);
        4: applyStimulus(16'h9999, 1'b1, 1'b0);
        6: applyStimulus(16'h9999, 1'b0, 1'b0);
        7: applyStimulus(16'h9999, 1'b1, 1'b0);
        8: applyStimulus(16'h9999, 1'b0, 1'b0);
        default: ;
      endcase
    end

    $display("[TB] asynchronous clr mid-scan");
    startScan(16'h0A05, 1'b1);
    @(negedge Counter_clk);
    applyStimulus(16'h0A05, 1'b0, 1'b0);
    for (int n = 2; n <= 10; n++) begin
      @(negedge Counter_clk);
      d = ((n - 1) / 4) % 4;
      checkOutput(0, "pre_clr", an_tab[d], seg_0a05[d], 1'b1, 1'b1);
    end
    #2;
    clr = 1'b0;
    applyStimulus(16'h1234, 1'b1, 1'b0);
    #1;
    checkOutput(0, "async_clr", 4'hF, 7'h7F, 1'b0, 1'b0);
    @(negedge Counter_clk);
    clr = 1'b1;
    @(negedge Counter_clk);
    checkOutput(0, "post_clr_cap", 4'hF, 7'h7F, 1'b1, 1'b0);
    applyStimulus(16'h1234, 1'b0, 1'b0);
    for (int n = 2; n <= 6; n++) begin
      @(negedge Counter_clk);
      d = ((n - 1) / 4) % 4;
      checkOutput(0, "post_clr_scan", an_tab[d], seg_1234[d], 1'b1, 1'b0);
    end

    #1;
    total_cnt++;
    if (exp_q.size() == 0) begin
      pass_cnt++;
    end else begin
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
